inst_mem_loader: RTL and testbench

Boot-time writer for the instruction memory: accepts a framed byte stream over a valid/ready handshake, packs bytes into 32-bit big-endian MIPS words and drives the instruction memory write port. It sits beside the single-cycle core and holds the core in reset until a program image is fully loaded. It is the write-side counterpart of the core's instruction fetch path, which only ever reads that memory.

---
 rtl/inst_mem_loader.sv | 159 +++++++++++++++
 tb/tb_inst_mem_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - framed byte-stream loader for the instruction memory; checksum via LOADER_CHECKSUM_EN
module inst_mem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        start,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [16:0] DEPTH_V = 17'd1 << ADDR_W;

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_CNT_H = 3'd1,
        S_CNT_L = 3'd2,
        S_DATA  = 3'd3,
        S_WRITE = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        S_CHK   = 3'd5,
`endif
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_LAST = S_CHK;
`else
    localparam state_t S_AFTER_LAST = S_DONE;
`endif

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_cnt_h;
    logic [15:0]     r_count;
    logic [31:0]     r_asm;
    logic [1:0]      r_byte_cnt;
    logic [ADDR_W:0] r_word_idx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      r_sum;
    logic [7:0]      w_chk_total;
`endif

    logic            w_accept;
    logic [15:0]     w_count;
    logic            w_too_big;
    logic [ADDR_W:0] w_idx_next;
    logic            w_more;
    logic [31:0]     w_idx32;

    assign w_accept   = rx_valid & rx_ready;
    assign w_count    = {r_cnt_h, rx_data};
    assign w_too_big  = {1'b0, w_count} > DEPTH_V;
    assign w_idx_next = r_word_idx + 1'b1;
    assign w_more     = 17'(w_idx_next) < {1'b0, r_count};
    assign w_idx32    = 32'(r_word_idx);
`ifdef LOADER_CHECKSUM_EN
    assign w_chk_total = r_sum + rx_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_SYNC;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SYNC:  if (w_accept && rx_data == 8'hA5) w_next = S_CNT_H;
            S_CNT_H: if (w_accept) w_next = S_CNT_L;
            S_CNT_L: begin
                if (w_accept) begin
                    if (w_too_big)             w_next = S_ERR;
                    else if (w_count == 16'd0) w_next = S_AFTER_LAST;
                    else                       w_next = S_DATA;
                end
            end
            S_DATA:  if (w_accept && r_byte_cnt == 2'd3) w_next = S_WRITE;
            S_WRITE: w_next = w_more ? S_DATA : S_AFTER_LAST;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:   if (w_accept) w_next = (w_chk_total == 8'h00) ? S_DONE : S_ERR;
`endif
            S_DONE:  if (start) w_next = S_SYNC;
            S_ERR:   if (start) w_next = S_SYNC;
            default: w_next = S_SYNC;
        endcase
    end

    // Outputs decode only from registered state so rx_valid never reaches them combinationally.
    always_comb begin
        rx_ready  = 1'b0;
        im_we     = 1'b0;
        cpu_reset = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (r_state)
            S_SYNC, S_CNT_H, S_CNT_L, S_DATA: rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:   rx_ready = 1'b1;
`endif
            S_WRITE: im_we = 1'b1;
            S_DONE: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
            end
            S_ERR:   load_err = 1'b1;
            default: ;
        endcase
    end

    assign im_wdata = r_asm;
    assign im_addr  = BASE_ADDR + (w_idx32 << 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_h    <= 8'd0;
            r_count    <= 16'd0;
            r_asm      <= 32'd0;
            r_byte_cnt <= 2'd0;
            r_word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_SYNC: begin
                    r_byte_cnt <= 2'd0;
                    r_word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                    r_sum      <= 8'd0;
`endif
                end
                S_CNT_H: if (w_accept) r_cnt_h <= rx_data;
                S_CNT_L: if (w_accept) r_count <= w_count;
                S_DATA: begin
                    if (w_accept) begin
                        r_asm      <= {r_asm[23:0], rx_data};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_sum      <= r_sum + rx_data;
`endif
                    end
                end
                S_WRITE: r_word_idx <= w_idx_next;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - scoreboard bench for inst_mem_loader with a frame-level reference model
module tb_inst_mem_loader;

    localparam int          ADDR_W = 8;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [31:0] BASE   = 32'h0040_0000;
    localparam int          OUT_NONE = 0, OUT_DONE = 1, OUT_ERR = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        start;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_reset;
    logic        load_done;
    logic        load_err;

    inst_mem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .start(start), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    bit          gaps = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("cpu_reset_vs_done", {31'd0, cpu_reset}, {31'd0, ~load_done});
            if (im_we === 1'b1) begin
                check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", im_addr, 32'hxxxx_xxxx);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", im_addr, e[63:32]);
                    check("write_data", im_wdata, e[31:0]);
                end
            end
        end
    end

    // Reference model: parse a whole frame, queue its writes, return the final outcome.
    task automatic model_frame(input logic [7:0] f[$], output int outcome);
        int          i = 0;
        int          n;
        logic [7:0]  sum = 8'd0;
        logic [31:0] word;
        while (i < f.size() && f[i] != 8'hA5) i++;
        n = {f[i+1], f[i+2]};
        i += 3;
        if (n > DEPTH) begin
            outcome = OUT_ERR;
            return;
        end
        for (int w = 0; w < n; w++) begin
            word = {f[i], f[i+1], f[i+2], f[i+3]};
            sum  = sum + f[i] + f[i+1] + f[i+2] + f[i+3];
            exp_q.push_back({BASE + 32'(4 * w), word});
            i += 4;
        end
`ifdef LOADER_CHECKSUM_EN
        outcome = (8'(sum + f[i]) == 8'h00) ? OUT_DONE : OUT_ERR;
`else
        outcome = OUT_DONE;
`endif
    endtask

    task automatic build_frame(input int n, input int junk, input bit bad_chk, output logic [7:0] f[$]);
        logic [7:0] b;
        logic [7:0] sum = 8'd0;
        f = {};
        for (int j = 0; j < junk; j++) begin
            b = 8'($urandom_range(0, 255));
            f.push_back((b == 8'hA5) ? 8'h00 : b);
        end
        f.push_back(8'hA5);
        f.push_back(8'(n >> 8));
        f.push_back(8'(n));
        if (n > DEPTH) return;
        for (int j = 0; j < 4 * n; j++) begin
            b = 8'($urandom_range(0, 255));
            sum = sum + b;
            f.push_back(b);
        end
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'(8'd0 - sum) + (bad_chk ? 8'd1 : 8'd0));
`else
        if (bad_chk) sum = 8'd0;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
        rx_valid = 1'b0;
        if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("rst_im_we", {31'd0, im_we}, 32'd0);
        check("rst_im_addr", im_addr, BASE);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_load_err", {31'd0, load_err}, 32'd0);
    endtask

    task automatic run_frame(input logic [7:0] f[$], input string tag);
        int outcome;
        int t = 0;
        model_frame(f, outcome);
        foreach (f[k]) send_byte(f[k]);
        while (load_done !== 1'b1 && load_err !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done"}, {31'd0, load_done}, {31'd0, outcome == OUT_DONE});
        check({tag, "_err"}, {31'd0, load_err}, {31'd0, outcome == OUT_ERR});
        check({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, outcome != OUT_DONE});
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q = {};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_restart_done"}, {31'd0, load_done}, 32'd0);
        check({tag, "_restart_err"}, {31'd0, load_err}, 32'd0);
        check({tag, "_restart_ready"}, {31'd0, rx_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] f[$];
        logic [7:0] sum;
        reset = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        do_reset();

        // Two-word program image from the bring-up example.
        f = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
`ifdef LOADER_CHECKSUM_EN
        sum = 8'h24 + 8'h08 + 8'h05 + 8'h01 + 8'h09 + 8'h50 + 8'h20;
        f.push_back(8'd0 - sum);
`endif
        run_frame(f, "prog2");

        f = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
        f.push_back(8'h00);
`endif
        run_frame(f, "junk_empty");

        f = '{8'hA5, 8'h01, 8'h01};
        run_frame(f, "too_big");

        build_frame(DEPTH, 0, 1'b0, f);
        run_frame(f, "full_depth");

`ifdef LOADER_CHECKSUM_EN
        build_frame(1, 0, 1'b1, f);
        run_frame(f, "bad_chk");
        build_frame(1, 0, 1'b0, f);
        run_frame(f, "good_chk");
`endif

        gaps = 1;
        build_frame(3, 1, 1'b0, f);
        run_frame(f, "gapped");
        gaps = 0;

        // Abort mid-word; only the following frame may produce writes.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        do_reset();
        build_frame(2, 0, 1'b0, f);
        run_frame(f, "after_abort");

        for (int r = 0; r < 10; r++) begin
            int n;
            gaps = $urandom_range(0, 1);
            n = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH + 1, DEPTH + 40) : $urandom_range(0, 5);
            build_frame(n, $urandom_range(0, 2), $urandom_range(0, 3) == 0, f);
            run_frame(f, "rand");
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
